// File: rtl/wb_intercon.sv
// Single-master, N-slave pipelined Wishbone interconnect: base/mask decode, response mux, bus error on miss/timeout.
// Define WB_INTERCON_ACK_REG_EN to register ack/err/data, which adds one cycle of response latency.
module wb_intercon #(
  parameter int                    NSLAVES    = 4,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE = {32'hd0000000, 32'hc0000000, 32'hb0008000, 32'hb0000000},
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK = {32'hffff0000, 32'hffff0000, 32'hffff8000, 32'hffff8000},
  parameter int                    TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [31:0]             i_wb_addr,
  input  logic [31:0]             i_wb_data,
  input  logic [1:0]              i_data_width,
  output logic                    o_wb_ack,
  output logic                    o_wb_stall,
  output logic                    o_wb_err,
  output logic [31:0]             o_wb_data,
  output logic [31:0]             o_fault_addr,
  output logic [NSLAVES-1:0]      o_s_cyc,
  output logic [NSLAVES-1:0]      o_s_stb,
  output logic                    o_s_we,
  output logic [31:0]             o_s_addr,
  output logic [31:0]             o_s_data,
  output logic [1:0]              o_s_width,
  input  logic [NSLAVES-1:0]      i_s_ack,
  input  logic [NSLAVES-1:0]      i_s_stall,
  input  logic [NSLAVES*32-1:0]   i_s_data
);

  localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_ERROR, S_RESP} state_t;

`ifdef WB_INTERCON_ACK_REG_EN
  localparam state_t S_DONE = S_RESP;
`else
  localparam state_t S_DONE = S_IDLE;
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   fault_q, fault_d;

  logic [NSLAVES-1:0] hit;
  logic [31:0]        s_rdata [NSLAVES];
  logic               hit_any;
  logic [IW-1:0]      hit_idx;

  logic [NSLAVES-1:0] s_cyc, s_stb;
  logic               stall, rsp_ack_d, rsp_err_d;
  logic [31:0]        rsp_data_d;

  generate
    for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_slave
      assign hit[gi]     = (i_wb_addr & SLAVE_MASK[gi*32 +: 32]) == SLAVE_BASE[gi*32 +: 32];
      assign s_rdata[gi] = i_s_data[gi*32 +: 32];
    end
  endgenerate

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = |hit;
    hit_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    fault_d    = fault_q;
    s_cyc      = '0;
    s_stb      = '0;
    stall      = 1'b0;
    rsp_ack_d  = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = s_rdata[idx_q];
    case (state_q)
      S_IDLE: begin
        stall = hit_any & i_s_stall[hit_idx];
        if (i_wb_cyc && i_wb_stb) begin
          if (hit_any) begin
            s_cyc[hit_idx] = 1'b1;
            s_stb[hit_idx] = 1'b1;
            if (!i_s_stall[hit_idx]) begin
              idx_d   = hit_idx;
              cnt_d   = '0;
              addr_d  = i_wb_addr;
              state_d = S_WAIT_ACK;
            end
          end else begin
            stall   = 1'b0;
            fault_d = i_wb_addr;
            state_d = S_ERROR;
          end
        end
      end
      S_WAIT_ACK: begin
        stall        = 1'b1;
        s_cyc[idx_q] = 1'b1;
        rsp_ack_d    = i_s_ack[idx_q];
        // Ack takes priority over both abort and timeout.
        if (i_s_ack[idx_q]) begin
          state_d = S_DONE;
        end else if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = cnt_q + 1'b1;
          fault_d = addr_q;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERROR: begin
        stall     = 1'b1;
        rsp_err_d = 1'b1;
        state_d   = S_DONE;
      end
      S_RESP: begin
        stall   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

`ifdef WB_INTERCON_ACK_REG_EN
  logic        rsp_ack_q, rsp_err_q;
  logic [31:0] rsp_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_ack_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      rsp_ack_q  <= rsp_ack_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign o_wb_ack  = rsp_ack_q;
  assign o_wb_err  = rsp_err_q;
  assign o_wb_data = rsp_data_q;
`else
  assign o_wb_ack  = rsp_ack_d & ~reset;
  assign o_wb_err  = rsp_err_d & ~reset;
  assign o_wb_data = rsp_data_d;
`endif

  // Slave strobes are gated so a master still driving cyc/stb cannot leak through reset.
  assign o_s_cyc      = reset ? '0 : s_cyc;
  assign o_s_stb      = reset ? '0 : s_stb;
  assign o_wb_stall   = stall;
  assign o_fault_addr = fault_q;
  assign o_s_we       = i_wb_we;
  assign o_s_addr     = i_wb_addr;
  assign o_s_data     = i_wb_data;
  assign o_s_width    = i_data_width;

endmodule

// File: tb/tb_wb_intercon.sv
// Directed plus randomized bench for wb_intercon, checked against an address-map/timing reference model.
module tb_wb_intercon;

  localparam int NS      = 4;
  localparam int TIMEOUT = 255;
`ifdef WB_INTERCON_ACK_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam logic [127:0] BASE     = {32'hd0000000, 32'hc0000000, 32'hb0008000, 32'hb0000000};
  localparam logic [127:0] MASK     = {32'hffff0000, 32'hffff0000, 32'hffff8000, 32'hffff8000};
  localparam logic [127:0] OVL_BASE = {32'hb0000000, 32'hc0000000, 32'hb0008000, 32'hb0000000};
  localparam logic [127:0] OVL_MASK = {32'hffff0000, 32'hffff0000, 32'hffff8000, 32'hffff8000};

  logic          clk, reset;
  logic          cyc, stb, we;
  logic [31:0]   addr, wdata;
  logic [1:0]    width;
  logic          ack, stall, err;
  logic [31:0]   rdata, fault;
  logic [NS-1:0] s_cyc, s_stb;
  logic          s_we;
  logic [31:0]   s_addr, s_data;
  logic [1:0]    s_width;
  logic [NS-1:0] s_ack, s_stall;
  logic [127:0]  s_rdata;

  logic          ov_ack, ov_stall, ov_err, ov_s_we;
  logic [31:0]   ov_rdata, ov_fault, ov_s_addr, ov_s_data;
  logic [NS-1:0] ov_s_cyc, ov_s_stb;
  logic [1:0]    ov_s_width;

  logic [127:0] base_v, mask_v, ovl_base_v, ovl_mask_v;
  int ncmp = 0;
  int nerr = 0;

  wb_intercon #(.NSLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_data_width(width),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_err(err), .o_wb_data(rdata),
    .o_fault_addr(fault), .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
    .o_s_addr(s_addr), .o_s_data(s_data), .o_s_width(s_width),
    .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_rdata)
  );

  wb_intercon #(.NSLAVES(NS), .SLAVE_BASE(OVL_BASE), .SLAVE_MASK(OVL_MASK), .TIMEOUT(TIMEOUT)) dut_ovl (
    .clk(clk), .reset(reset), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_data_width(width),
    .o_wb_ack(ov_ack), .o_wb_stall(ov_stall), .o_wb_err(ov_err), .o_wb_data(ov_rdata),
    .o_fault_addr(ov_fault), .o_s_cyc(ov_s_cyc), .o_s_stb(ov_s_stb), .o_s_we(ov_s_we),
    .o_s_addr(ov_s_addr), .o_s_data(ov_s_data), .o_s_width(ov_s_width),
    .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference address map: first slave (lowest index) whose masked base matches, else -1.
  function automatic int ref_decode(input logic [31:0] a, input logic [127:0] b, input logic [127:0] m);
    for (int k = 0; k < NS; k++) begin
      if ((a & m[k*32 +: 32]) == b[k*32 +: 32]) return k;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_sdata(input int tgt, input logic [31:0] v);
    for (int k = 0; k < NS; k++) s_rdata[k*32 +: 32] = (k == tgt) ? v : $urandom;
  endtask

  // One master transaction; nstall = slave stall cycles, dly = cycles from acceptance to slave ack.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input int nstall, input int dly, input logic [31:0] rd);
    int t;
    logic [3:0] oh;
    t  = ref_decode(a, base_v, mask_v);
    oh = (t >= 0) ? 4'(1 << t) : 4'b0;
    $display("txn addr=%08h we=%0d slave=%0d stall=%0d dly=%0d rd=%08h", a, w, t, nstall, dly, rd);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = wd; width = 2'($urandom);
    s_ack = '0;
    if (t < 0) begin
      s_stall = 4'($urandom);
      #1;
      chk("unm_stall", stall, 0);
      chk("unm_stb", s_stb, 0);
      chk("unm_cyc", s_cyc, 0);
      step();
      stb = 1'b0;
      for (int l = 0; l < LAT; l++) begin
        #1; chk("unm_err_lat", err, 0); step();
      end
      #1;
      chk("unm_err", err, 1);
      chk("unm_ack", ack, 0);
      chk("unm_fault", fault, a);
      chk("unm_stb_err", s_stb, 0);
      step();
      #1;
      chk("unm_err_once", err, 0);
      cyc = 1'b0;
      step();
      return;
    end
    for (int c = 0; c < nstall; c++) begin
      s_stall = oh | (4'($urandom) & ~oh);
      #1;
      chk("req_stall", stall, 1);
      chk("req_stb", s_stb, oh);
      chk("req_cyc", s_cyc, oh);
      chk("bc_addr", s_addr, a);
      chk("bc_data", s_data, wd);
      chk("bc_we", s_we, w);
      chk("bc_width", s_width, width);
      step();
    end
    s_stall = 4'($urandom) & ~oh;
    #1;
    chk("acc_stall", stall, 0);
    chk("acc_stb", s_stb, oh);
    chk("acc_cyc", s_cyc, oh);
    chk("acc_data", s_data, wd);
    step();
    stb = 1'b0;
    for (int d = 1; d <= dly; d++) begin
      if (d == dly) begin
        s_ack = oh | (4'($urandom) & ~oh);
        set_sdata(t, rd);
      end else begin
        s_ack = 4'($urandom) & ~oh;
        set_sdata(t, $urandom);
      end
      #1;
      chk("wait_cyc", s_cyc, oh);
      chk("wait_stb", s_stb, 0);
      chk("wait_stall", stall, 1);
      chk("wait_err", err, 0);
      if (LAT == 0) begin
        chk("ack", ack, (d == dly) ? 1 : 0);
        if (d == dly) chk("rdata", rdata, rd);
      end else begin
        chk("ack_early", ack, 0);
      end
      step();
    end
    s_ack = '0;
    set_sdata(t, $urandom);
    if (LAT != 0) begin
      #1;
      chk("ack_reg", ack, 1);
      chk("rdata_reg", rdata, rd);
      chk("resp_stall", stall, 1);
      step();
    end
    #1;
    chk("ack_once", ack, 0);
    chk("post_err", err, 0);
    chk("post_cyc", s_cyc, 0);
    cyc = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] a;
    int k;
    base_v = BASE; mask_v = MASK; ovl_base_v = OVL_BASE; ovl_mask_v = OVL_MASK;
    reset = 1'b1; cyc = 0; stb = 0; we = 0; addr = 0; wdata = 0; width = 0;
    s_ack = 0; s_stall = 0; s_rdata = 0;
    @(negedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cyc", s_cyc, 0);
    chk("rst_stb", s_stb, 0);
    step();
    reset = 1'b0;
    step();

    // Directed scenarios.
    txn(32'hb0000004, 1'b0, 32'h0, 0, 2, 32'hdeadbeef);
    txn(32'hb0008010, 1'b1, 32'h12345678, 3, 1, 32'h0badf00d);
    txn(32'ha0000000, 1'b0, 32'h0, 0, 1, 32'h0);

    // Slave 2 never acks: error 256 cycles after acceptance, late ack ignored.
    $display("txn addr=c0000000 we=0 slave=2 timeout");
    cyc = 1; stb = 1; we = 0; addr = 32'hc0000000; s_stall = 0; s_ack = 0;
    #1;
    chk("to_acc_stb", s_stb, 4'b0100);
    step();
    stb = 0;
    for (int d = 1; d < TIMEOUT + 1; d++) begin
      #1;
      chk("to_cyc", s_cyc, 4'b0100);
      chk("to_noerr", err, 0);
      step();
    end
    #1;
    chk("to_cyc_drop", s_cyc, 0);
    chk("to_fault", fault, 32'hc0000000);
    if (LAT == 0) chk("to_err", err, 1);
    else chk("to_err_lat", err, 0);
    step();
    if (LAT != 0) begin
      #1; chk("to_err", err, 1); step();
    end
    s_ack = 4'b0100;
    #1;
    chk("late_ack", ack, 0);
    chk("late_err", err, 0);
    step();
    s_ack = 0; cyc = 0;
    step();

    // Reset in the middle of a slave-1 transaction.
    $display("txn addr=b0008000 we=0 slave=1 reset-mid");
    cyc = 1; stb = 1; addr = 32'hb0008000; s_stall = 0;
    #1;
    chk("rm_acc_stb", s_stb, 4'b0010);
    step();
    stb = 0;
    #1;
    chk("rm_wait_cyc", s_cyc, 4'b0010);
    chk("rm_fault_pre", fault, 32'hc0000000);
    reset = 1;
    #1;
    chk("rm_cyc", s_cyc, 0);
    chk("rm_fault", fault, 0);
    chk("rm_stall0", stall, 0);
    chk("rm_ack", ack, 0);
    s_stall = 4'b0010;
    #1;
    chk("rm_stall1", stall, 1);
    step();
    reset = 0; cyc = 0; s_stall = 0;
    step();
    txn(32'hb0008020, 1'b0, 32'h0, 1, 3, 32'hcafe0001);

    // Overlapping map: slave 0 and slave 3 both cover 0xb0000000.
    $display("txn addr=b0000000 overlap-decode");
    cyc = 1; stb = 1; addr = 32'hb0000000; s_stall = 0;
    #1;
    k = ref_decode(addr, ovl_base_v, ovl_mask_v);
    chk("ovl_stb", ov_s_stb, 4'(1 << k));
    chk("ovl_cyc", ov_s_cyc, 4'(1 << k));
    addr = 32'hb0010000;
    #1;
    k = ref_decode(addr, ovl_base_v, ovl_mask_v);
    chk("ovl_stb3", ov_s_stb, 4'(1 << k));
    cyc = 0; stb = 0;
    step();

    // Randomized traffic over every region plus random (mostly unmapped) addresses.
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, NS);
      if (k < NS) a = base_v[k*32 +: 32] | ($urandom & ~mask_v[k*32 +: 32]);
      else a = $urandom;
      txn(a, 1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(1, 5), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/wb_intercon.md
Name: wb_intercon

Overview:
- Parametrised single-master, N-slave Wishbone (pipelined) interconnect that replaces the fixed address compares in the SoC top.
- Decodes the CPU address against per-slave base/mask pairs and routes cyc/stb to the selected slave.
- Muxes ack, stall and read data back to the CPU.
- Generates a bus error for unmapped addresses and for slaves that never acknowledge, and records the faulting address.

Parameters:
- NSLAVES, 4, number of slave ports (1..8).
- SLAVE_BASE, {32'hd0000000, 32'hc0000000, 32'hb0008000, 32'hb0000000}, packed NSLAVES*32 base addresses; slave k uses bits [32k+31:32k].
- SLAVE_MASK, {32'hffff0000, 32'hffff0000, 32'hffff8000, 32'hffff8000}, packed NSLAVES*32 masks. Slave k hits when (addr & mask_k) == base_k.
- TIMEOUT, 255, cycles to wait for ack after acceptance before a bus error. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_wb_cyc  in  1  master cycle.
- i_wb_stb  in  1  master strobe.
- i_wb_we  in  1  master write enable.
- i_wb_addr  in  32  master byte address.
- i_wb_data  in  32  master write data.
- i_data_width  in  2  access width code, passed through.
- o_wb_ack  out  1  ack to master.
- o_wb_stall  out  1  stall to master.
- o_wb_err  out  1  one-cycle bus error to master.
- o_wb_data  out  32  read data to master.
- o_fault_addr  out  32  address of the most recent errored request.
- o_s_cyc  out  NSLAVES  per-slave cyc.
- o_s_stb  out  NSLAVES  per-slave stb.
- o_s_we  out  1  broadcast write enable.
- o_s_addr  out  32  broadcast address.
- o_s_data  out  32  broadcast write data.
- o_s_width  out  2  broadcast width code.
- i_s_ack  in  NSLAVES  per-slave ack.
- i_s_stall  in  NSLAVES  per-slave stall.
- i_s_data  in  NSLAVES*32  packed slave read data.

Behaviour:
- Reset values: state IDLE; o_s_cyc=0, o_s_stb=0, o_wb_ack=0, o_wb_err=0, o_fault_addr=0, timeout counter=0, latched slave index=0.
- Decode is combinational. On overlapping regions, the lowest index wins. Broadcast signals are direct passthroughs of the master signals.
- One outstanding transaction only.
- IDLE:
  - o_wb_stall follows i_s_stall of the decoded slave.
  - On cyc&stb with a hit on slave k, o_s_cyc[k] and o_s_stb[k] follow the master. When i_s_stall[k]=0, the request is accepted: latch k, clear the counter, go to WAIT_ACK.
  - On cyc&stb with no hit, o_wb_stall=0, no slave strobed, capture o_fault_addr=i_wb_addr, go to ERROR.
- WAIT_ACK:
  - o_wb_stall=1; o_s_cyc[k] held high; o_s_stb=0.
  - o_wb_ack=i_s_ack[k] combinationally; o_wb_data=i_s_data[k] (it may be anything when ack is low).
  - On ack, go to IDLE. The next request may be accepted the cycle after ack.
  - The counter increments each cycle without ack. When it reaches TIMEOUT, capture o_fault_addr from a register holding the accepted address, drop o_s_cyc[k], and go to ERROR.
- ERROR: o_wb_err=1 for exactly one cycle, o_wb_stall=1, o_wb_ack=0; then IDLE.
- Abort: i_wb_cyc low in WAIT_ACK returns to IDLE next cycle and drops o_s_cyc. A late slave ack is ignored.
- Ack and timeout in the same cycle: ack wins, no error.
- o_wb_ack and o_wb_err are never high together.
- Reset asserted mid-transaction: all outputs return immediately (asynchronously) to their reset values; o_fault_addr is cleared.

Optional Feature:
- Macro WB_INTERCON_ACK_REG_EN.
- Defined: o_wb_ack, o_wb_err and o_wb_data are registered, adding one cycle of response latency. The state machine returns to IDLE one cycle later, and the following request is stalled for that cycle.
- Undefined: responses are combinational from the latched slave as specified above.

Test Plan:
- Read 0xb0000004; slave0 acks 2 cycles after accept with data 0xdeadbeef -> o_s_stb[0] high one cycle; o_wb_ack one cycle with o_wb_data=0xdeadbeef; no other o_s_cyc bit ever high.
- Write 0xb0008010 data 0x12345678; slave1 stalls 3 cycles, then accepts -> o_wb_stall high exactly 3 cycles; o_s_data=0x12345678; o_s_we=1; ack routed from slave1.
- Read 0xa0000000 (unmapped) -> no o_s_stb bit set; o_wb_err high 1 cycle, 1 cycle after the request; o_fault_addr=0xa0000000.
- Read 0xc0000000 with slave2 never acking, TIMEOUT=255 -> o_wb_err 256 cycles after acceptance; o_s_cyc[2] drops; o_fault_addr=0xc0000000; a later slave2 ack is ignored.
- Overlap: set SLAVE_BASE so slave3 also maps 0xb0000000 -> read 0xb0000000 routes to slave0 only.
- Assert reset during WAIT_ACK -> o_s_cyc=0, o_wb_stall follows IDLE rules, and o_fault_addr=0 within the same cycle; a new request is served normally after reset.
